// File: rtl/if_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer: default widths,
// the all-zero word and the fetch address stride.
package if_buffer_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    localparam int PC_STEP = 4;

    // Number of bits needed to hold an occupancy value from 0 to depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Circular store for fetched {pc, instruction} pairs. Holds its head,
// tail and occupancy count; a flush empties it in one cycle.
module if_fifo
    import if_buffer_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH + INST_WIDTH,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer and count update; both pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/if_buffer.sv
// Instruction-fetch buffer: issues sequential ROM fetches, queues the
// returned instructions and offers them in order to decode. A redirect
// flushes everything and restarts fetching at the branch target.
// Optional build macro IF_BYPASS_EN: a response arriving while the queue
// is empty is offered to decode in the same cycle (1-cycle latency).
module if_buffer
    import if_buffer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_WIDTH,
    parameter int                INST_W   = INST_WIDTH,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0]        pc_q;
    logic [ADDR_W-1:0]        resp_pc_q;
    logic                     inflight_q;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W+INST_W-1:0] head_entry;
    logic                     fifo_empty;
    logic                     bypass_hit;
    logic                     active;
    logic                     pop;
    logic                     fifo_pop;
    logic                     push;
    logic [CNT_W:0]           occupancy;
    logic [ADDR_W-1:0]        head_pc;
    logic [INST_W-1:0]        head_inst;

    assign fifo_empty = (count == '0);
    assign active     = !rst && !branch_flag_i;

`ifdef IF_BYPASS_EN
    assign bypass_hit = fifo_empty && inflight_q;
`else
    assign bypass_hit = 1'b0;
`endif

    assign id_valid_o = active && (!fifo_empty || bypass_hit);
    assign pop        = id_valid_o && id_ready_i;
    assign fifo_pop   = pop && !fifo_empty;
    // A bypassed response that decode takes immediately never enters the queue.
    assign push       = active && inflight_q && !(bypass_hit && pop);

    // Slots already committed (stored + in flight) after this cycle's pop.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign rom_ce_o  = active && (occupancy < (CNT_W+1)'(DEPTH));
    assign rom_addr_o = rst ? ADDR_W'(ZERO_ADDR) : pc_q;

    assign head_pc   = bypass_hit ? resp_pc_q  : head_entry[ADDR_W+INST_W-1:INST_W];
    assign head_inst = bypass_hit ? rom_data_i : head_entry[INST_W-1:0];
    assign id_pc_o   = id_valid_o ? head_pc   : ADDR_W'(ZERO_ADDR);
    assign id_inst_o = id_valid_o ? head_inst : INST_W'(ZERO_WORD);

    // Fetch PC and the single outstanding request; redirect outranks all.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else if (branch_flag_i) begin
            pc_q       <= branch_target_i;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rom_ce_o;
            if (rom_ce_o) begin
                resp_pc_q <= pc_q;
                pc_q      <= pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    if_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_flag_i),
        .push  (push),
        .pop   (fifo_pop),
        .wdata ({resp_pc_q, rom_data_i}),
        .rdata (head_entry),
        .count (count)
    );

endmodule

// File: tb/tb_if_buffer.sv
// Bench for if_buffer: directed scenarios plus random ready/redirect/reset
// traffic, checked every cycle against a queue-based reference model.
module tb_if_buffer;

    localparam int DEPTH = 4;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i = 1'b0;

    if_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_ready_i      (id_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_pc = '0;

    // ROM environment and delivery log
    logic        prev_ce = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] got_pc[$];
    int          got_cyc[$];
    int          cyc = 0;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a ^ 32'h5EED_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] tgt, input logic rdy);
        logic        e_ce, e_valid, has_q, byp, pop;
        logic [31:0] e_addr, e_pc, e_inst, hpc;
        int          occ;
        @(negedge clk);
        rom_data_i      = prev_ce ? rom_f(prev_addr) : $urandom;
        rst             = r;
        branch_flag_i   = b;
        branch_target_i = tgt;
        id_ready_i      = rdy;
        #1;
        e_ce = 0; e_valid = 0; e_addr = '0; e_pc = '0; e_inst = '0;
        has_q = 0; byp = 0; pop = 0; hpc = '0;
        if (r) begin
            e_addr = '0;
        end else if (b) begin
            e_addr = m_pc;
        end else begin
            has_q   = (m_q.size() > 0);
            byp     = BYP && !has_q && m_infl;
            e_valid = has_q || byp;
            hpc     = has_q ? m_q[0] : m_infl_pc;
            pop     = e_valid && rdy;
            occ     = m_q.size() + int'(m_infl) - int'(pop);
            e_ce    = (occ < DEPTH);
            e_addr  = m_pc;
            if (e_valid) begin
                e_pc   = hpc;
                e_inst = rom_f(hpc);
            end
        end
        chk("rom_ce",   64'(rom_ce_o),   64'(e_ce));
        chk("rom_addr", 64'(rom_addr_o), 64'(e_addr));
        chk("id_valid", 64'(id_valid_o), 64'(e_valid));
        chk("id_pc",    64'(id_pc_o),    64'(e_pc));
        chk("id_inst",  64'(id_inst_o),  64'(e_inst));
        if (id_valid_o && rdy) begin
            got_pc.push_back(id_pc_o);
            got_cyc.push_back(cyc);
        end
        prev_ce   = rom_ce_o;
        prev_addr = rom_addr_o;
        if (r) begin
            m_q.delete(); m_infl = 0; m_pc = 32'h0;
        end else if (b) begin
            m_q.delete(); m_infl = 0; m_pc = tgt;
        end else begin
            if (pop && has_q) void'(m_q.pop_front());
            if (m_infl && !(byp && pop)) m_q.push_back(m_infl_pc);
            m_infl = e_ce;
            if (e_ce) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic clear_log();
        got_pc.delete();
        got_cyc.delete();
    endtask

    initial begin
        int k;
        // Streaming from reset
        repeat (3) step(1, 0, 0, 1);
        repeat (20) step(0, 0, 0, 1);

        // Stall with buffer filling, then release
        repeat (2) step(1, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0);
        clear_log();
        repeat (10) step(0, 0, 0, 1);
        chk("stall_n", 64'(got_pc.size() >= 5), 64'd1);
        if (got_pc.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("stall_pc",  64'(got_pc[i]), 64'(32'(i * 4)));
                chk("stall_gap", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
            end

        // Redirect while full
        repeat (8) step(0, 0, 0, 0);
        clear_log();
        step(0, 1, 32'h100, 1);
        repeat (10) step(0, 0, 0, 1);
        chk("redir_first", 64'(got_pc.size() > 0 ? got_pc[0] : 32'hDEAD), 64'h100);

        // Redirect colliding with pop and response in steady streaming
        repeat (6) step(0, 0, 0, 1);
        step(0, 1, 32'h200, 1);
        clear_log();
        repeat (6) step(0, 0, 0, 1);
        chk("redir2_first", 64'(got_pc.size() > 0 ? got_pc[0] : 32'hDEAD), 64'h200);

        // Reset pulse with a request in flight
        repeat (4) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        clear_log();
        repeat (6) step(0, 0, 0, 1);
        chk("rst_first", 64'(got_pc.size() > 0 ? got_pc[0] : 32'hDEAD), 64'h0);

        // Address wrap past 0xFFFFFFFC and many pointer wraps
        step(0, 1, 32'hFFFF_FFF0, 1);
        clear_log();
        repeat (20) step(0, 0, 0, 1);
        k = -1;
        for (int i = 0; i < got_pc.size(); i++)
            if (k < 0 && got_pc[i] == 32'hFFFF_FFFC) k = i;
        chk("wrap_found", 64'(k >= 0), 64'd1);
        chk("wrap_pops", 64'(got_pc.size() >= 3 * DEPTH), 64'd1);
        if (k >= 0 && k + 1 < got_pc.size())
            chk("wrap_next", 64'(got_pc[k+1]), 64'h0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic rr, bb, rdy;
            rr  = ($urandom_range(0, 127) == 0);
            bb  = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(rr, bb, $urandom & 32'hFFFF_FFFC, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_buffer.md
IF_BUFFER -- requirements
Module: if_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning instruction address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning buffer entries; legal values are powers of two, 2 or greater.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 SHALL have ports clk input 1 (system clock, rising edge) and rst input 1 (reset, synchronous, active-high).
REQ-006 SHALL have rom_ce_o output 1: fetch request this cycle.
REQ-007 SHALL have rom_addr_o output ADDR_W: fetch address.
REQ-008 SHALL have rom_data_i input INST_W: instruction returned exactly 1 cycle after rom_ce_o.
REQ-009 SHALL have branch_flag_i input 1 (redirect request) and branch_target_i input ADDR_W (redirect address).
REQ-010 SHALL have id_valid_o output 1, id_pc_o output ADDR_W and id_inst_o output INST_W: the head entry offered to decode.
REQ-011 SHALL have id_ready_i input 1: decode accepts the head entry.

Function
REQ-012 SHALL transfer the head entry ("pop") only in a cycle where id_valid_o=1 and id_ready_i=1.
REQ-013 SHALL drive id_pc_o and id_inst_o to zero whenever id_valid_o=0.
REQ-014 SHALL assert rom_ce_o when rst=0, branch_flag_i=0 and (count + inflight − pop) < DEPTH; rom_addr_o SHALL equal the fetch PC.
REQ-015 SHALL advance the fetch PC by 4 on every issued request, wrapping modulo 2^ADDR_W.
REQ-016 SHALL write a response {fetch address, rom_data_i} into the tail in the cycle after an issue; inflight is 0 or 1.
REQ-017 SHALL never overflow; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-018 SHALL keep order: entries leave in fetch order, and head and tail pointers wrap modulo DEPTH.
REQ-019 SHALL treat branch_flag_i=1 as follows: force id_valid_o=0 and rom_ce_o=0, discard all entries and the response arriving that cycle, set inflight=0 and fetch PC=branch_target_i; fetching resumes from the target the next cycle.
REQ-020 SHALL give redirect priority over pop and push in the same cycle.
REQ-021 SHALL hold all entries stable while id_ready_i=0, with no loss or duplication.
REQ-022 SHALL sustain one instruction per cycle when id_ready_i stays 1.

Reset
REQ-023 SHALL, while rst=1, set fetch PC=RESET_PC, count=0, inflight=0, pointers=0, rom_ce_o=0 and id_valid_o=0, and drive id_pc_o, id_inst_o and rom_addr_o to 0.
REQ-024 SHALL discard any in-flight response when rst asserts mid-operation; the first request after rst falls SHALL be to RESET_PC.

Configuration
REQ-025 SHALL support macro IF_BYPASS_EN; when defined, a response arriving with the buffer empty is presented on the id_* outputs in the same cycle and is not stored if popped, giving 1-cycle request-to-valid latency.
REQ-026 SHALL, without IF_BYPASS_EN, always store the response first, so it becomes visible the next cycle (2-cycle latency).

Structure
REQ-027 SHALL take the ZeroWord, instruction-width and address-width constants from the shared defs.v definitions, not local literals.
REQ-028 SHALL implement the circular store and its pointers and count in one sub-module, if_fifo, parametrised by width and DEPTH.

Verification
REQ-029 SHALL cover: reset released with RESET_PC=0 and id_ready_i=1 -> rom_addr_o 0,4,8,…; id_pc_o/id_inst_o match the ROM each cycle after the initial latency (2 cycles, or 1 with IF_BYPASS_EN).
REQ-030 SHALL cover: id_ready_i=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered and rom_ce_o=0; on release, PCs 0,4,8,12,16 are delivered in order with no gap.
REQ-031 SHALL cover: branch_flag_i=1 with target 0x100 while the buffer is full -> id_valid_o=0 that cycle; next rom_addr_o=0x100; no pre-redirect PC ever appears on id_pc_o.
REQ-032 SHALL cover: redirect in the same cycle as a pop and a response -> neither is delivered; count=0.
REQ-033 SHALL cover: rst pulsed while inflight=1 -> stale instruction dropped; first delivered id_pc_o=RESET_PC.
REQ-034 SHALL cover: fetch PC at 0xFFFFFFFC -> next rom_addr_o=0x0, and pointer wrap is exercised over at least 3×DEPTH pops.
